// File: rtl/crossbar_pkg.sv
// Shared definitions for the 4x4 crossbar switch.
// Holds the datapath width, port count and port-index width, the position of the
// destination field inside a header word, and the state types of the ingress
// port controller FSMs.
package crossbar_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned NumPorts = 4;
  localparam int unsigned PortIdxW = 2;

  // Destination output port lives in the top bits of the header word.
  localparam int unsigned DestMsb = DataW - 1;
  localparam int unsigned DestLsb = DataW - PortIdxW;

  typedef enum logic [1:0] {
    EgIdle,
    EgReq,
    EgXfer
  } eg_state_e;

  typedef enum logic {
    InNorm,
    InDrop
  } in_state_e;

endpackage

// File: rtl/inport_fifo.sv
// Synchronous FIFO holding {last, data} entries for one crossbar input port.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// The write pointer can be rewound to a saved position, which discards any
// words written after that position.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   wr_en_i             write {wr_last_i, wr_data_i} at the write pointer
//   rewind_i            load the write pointer from rewind_ptr_i
//   rd_en_i             pop the head entry
//   rd_data_o/rd_last_o head entry (valid when !empty_o)
//   full_o, empty_o     occupancy flags
//   wr_ptr_o            current write pointer, including wrap bit
module inport_fifo #(
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned PtrW  = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic             wr_last_i,
  input  logic             rewind_i,
  input  logic [PtrW-1:0]  rewind_ptr_i,
  input  logic             rd_en_i,
  output logic [DataW-1:0] rd_data_o,
  output logic             rd_last_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW-1:0]  wr_ptr_o
);

  logic [DataW:0]    mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (rewind_i) begin
      wr_ptr_d = rewind_ptr_i;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
  end

  assign rd_ptr_d = rd_en_i ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: every read is qualified by the occupancy flags.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= {wr_last_i, wr_data_i};
    end
  end

  assign {rd_last_o, rd_data_o} = mem_q[rd_ptr_q[AddrW-1:0]];

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign wr_ptr_o = wr_ptr_q;

endmodule

// File: rtl/crossbar_in_port.sv
// Ingress controller for one input of the 4x4 crossbar. Buffers packets
// store-and-forward, requests an output once a complete packet sits at the FIFO
// head, and streams it into the crossbar while granted. Packets longer than the
// FIFO are discarded.
//
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   in_data_i/in_valid_i/in_last_i/in_ready_o   ingress link
//   req_o, addr_o                          request and header word to arbiter
//   gnt_i                                  grant from arbiter
//   out_data_o/out_valid_o/out_last_o/out_ready_i  link into the crossbar
//   pkt_tx_cnt_o, drop_cnt_o               saturating statistics
//
// Build option: define INPORT_STATS_EN to implement the statistics counters;
// otherwise both statistics outputs read 0.
module crossbar_in_port
  import crossbar_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              req_o,
  output logic [DATA_W-1:0] addr_o,
  input  logic              gnt_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic [15:0]       pkt_tx_cnt_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH) + 1;

  in_state_e in_st_q, in_st_d;
  eg_state_e eg_st_q, eg_st_d;

  logic [PtrW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [PtrW-1:0]   wr_start_q, wr_start_d;
  logic [PtrW-1:0]   wr_ptr;
  logic [DATA_W-1:0] head_data;
  logic              head_last, full, empty;
  logic              wr_en, wr_last, drop_start, pop, pkt_done;

  inport_fifo #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_en_i      (wr_en),
    .wr_data_i    (in_data_i),
    .wr_last_i    (in_last_i),
    .rewind_i     (drop_start),
    .rewind_ptr_i (wr_start_q),
    .rd_en_i      (pop),
    .rd_data_o    (head_data),
    .rd_last_o    (head_last),
    .full_o       (full),
    .empty_o      (empty),
    .wr_ptr_o     (wr_ptr)
  );

  // Ingress: a full FIFO with no complete packet means the packet being
  // written cannot fit, so drop it and swallow the rest of it.
  always_comb begin
    in_st_d    = in_st_q;
    in_ready_o = 1'b0;
    drop_start = 1'b0;
    unique case (in_st_q)
      InNorm: begin
        in_ready_o = rst_ni & ~full;
        if (full && in_valid_i && (pkt_cnt_q == '0)) begin
          drop_start = 1'b1;
          in_st_d    = InDrop;
        end
      end
      InDrop: begin
        in_ready_o = rst_ni;
        if (in_valid_i && in_last_i) begin
          in_st_d = InNorm;
        end
      end
      default: in_st_d = InNorm;
    endcase
  end

  assign wr_en   = (in_st_q == InNorm) && in_valid_i && in_ready_o;
  assign wr_last = wr_en && in_last_i;

  // The next packet starts right after the last word of the previous one.
  assign wr_start_d = wr_last ? wr_ptr + PtrW'(1) : wr_start_q;

  // Egress
  assign out_valid_o = (eg_st_q == EgXfer) && gnt_i && !empty;
  assign pop         = out_valid_o && out_ready_i;
  assign pkt_done    = pop && head_last;
  assign out_data_o  = out_valid_o ? head_data : '0;
  assign out_last_o  = out_valid_o && head_last;
  assign req_o       = (eg_st_q == EgReq);
  // Head is not popped before XFER, so addr holds steady while requesting.
  assign addr_o      = req_o ? head_data : '0;

  always_comb begin
    eg_st_d = eg_st_q;
    unique case (eg_st_q)
      EgIdle:  if (pkt_cnt_q != '0) eg_st_d = EgReq;
      EgReq:   if (gnt_i) eg_st_d = EgXfer;
      EgXfer:  if (pkt_done) eg_st_d = EgIdle;
      default: eg_st_d = EgIdle;
    endcase
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (wr_last && !pkt_done) begin
      pkt_cnt_d = pkt_cnt_q + PtrW'(1);
    end else if (!wr_last && pkt_done) begin
      pkt_cnt_d = pkt_cnt_q - PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_st_q    <= InNorm;
      eg_st_q    <= EgIdle;
      pkt_cnt_q  <= '0;
      wr_start_q <= '0;
    end else begin
      in_st_q    <= in_st_d;
      eg_st_q    <= eg_st_d;
      pkt_cnt_q  <= pkt_cnt_d;
      wr_start_q <= wr_start_d;
    end
  end

`ifdef INPORT_STATS_EN
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign tx_cnt_d   = (pkt_done && (tx_cnt_q != 16'hFFFF)) ? tx_cnt_q + 16'd1 : tx_cnt_q;
  assign drop_cnt_d = (drop_start && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 :
                                                                  drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_tx_cnt_o = tx_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;
`else
  assign pkt_tx_cnt_o = '0;
  assign drop_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_crossbar_in_port.sv
// Randomized bench for crossbar_in_port. The reference model works at packet
// level: a packet of at most DEPTH words is forwarded unchanged and in order,
// a longer one is dropped entirely.
module tb_crossbar_in_port;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic          req, gnt;
  logic [DW-1:0] addr, out_data;
  logic          out_valid, out_last, out_ready;
  logic [15:0]   pkt_tx_cnt, drop_cnt;

  always #5 clk = ~clk;

  crossbar_in_port #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_last_i    (in_last),
    .in_ready_o   (in_ready),
    .req_o        (req),
    .addr_o       (addr),
    .gnt_i        (gnt),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_last_o   (out_last),
    .out_ready_i  (out_ready),
    .pkt_tx_cnt_o (pkt_tx_cnt),
    .drop_cnt_o   (drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW:0] exp_q[$];   // {last, data} of words still to come out
  int exp_tx = 0, exp_drop = 0, exp_words = 0, words_out = 0;
  bit bg_en = 1'b0;
  bit mid_pkt = 1'b0, post_last = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic int stat_exp(input int v);
`ifdef INPORT_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check_stats(input string tag);
    check_eq({tag, "_tx"}, pkt_tx_cnt, stat_exp(exp_tx));
    check_eq({tag, "_drop"}, drop_cnt, stat_exp(exp_drop));
  endtask

  // Called at posedge+1; returns at posedge+1 after the last word is taken.
  task automatic send_pkt(input int len, input logic [1:0] dest);
    logic [DW:0] words[$];
    logic [DW-1:0] w;
    int t;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      if (i == 0) w[DW-1:DW-2] = dest;
      words.push_back({(i == len - 1), w});
    end
    if (len <= DEPTH) begin
      foreach (words[i]) exp_q.push_back(words[i]);
      exp_tx++;
      exp_words += len;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = words[i][DW-1:0];
      in_last  = words[i][DW];
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        check_eq("in_ready_wait", in_ready, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq(tag, exp_q.size(), 0);
  endtask

  // Monitor: output words against the model, addr while requesting,
  // no output while grant is withdrawn, and a req-free cycle after each packet.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (bg_en) begin
        if (post_last) begin
          check_eq("req_gap", req, 0);
          post_last = 1'b0;
        end
        if (req) begin
          if (exp_q.size() == 0) check_eq("req_no_pkt", req, 0);
          else check_eq("addr", addr, exp_q[0][DW-1:0]);
        end
        if (!gnt && mid_pkt) check_eq("paused_valid", out_valid, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_word", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("out_data", out_data, e[DW-1:0]);
            check_eq("out_last", out_last, e[DW]);
            words_out++;
            mid_pkt = !out_last;
            if (out_last) post_last = 1'b1;
          end
        end
      end
    end
  end

  // Arbiter model: grant after a random delay, withdraw it for 1-4 cycles at random.
  initial begin
    int t, pause;
    forever begin
      @(negedge clk);
      if (bg_en && req) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        gnt = 1'b1;
        t = 0;
        pause = 0;
        forever begin
          @(negedge clk);
          if (out_valid && out_ready && out_last) begin
            @(posedge clk); #1;
            gnt = 1'b0;
            break;
          end
          t++;
          if (t > 5000) begin
            check_eq("xfer_timeout", out_last, 1);
            gnt = 1'b0;
            break;
          end
          @(posedge clk); #1;
          if (gnt) begin
            if ($urandom_range(0, 5) == 0) begin
              gnt = 1'b0;
              pause = $urandom_range(1, 4);
            end
          end else begin
            pause--;
            if (pause <= 0) gnt = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bg_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, len;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    gnt = 1'b0; out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_req", req, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_out_data", out_data, 0);
    check_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;
    bg_en = 1'b1;

    send_pkt(3, 2'b10);
    wait_drain("drain_3w");
    check_stats("after_3w");
    send_pkt(DEPTH, 2'($urandom));
    wait_drain("drain_16w");
    check_stats("after_16w");
    send_pkt(20, 2'($urandom));
    send_pkt(2, 2'($urandom));
    wait_drain("drain_20w_2w");
    check_stats("after_drop");

    // Back-to-back random traffic, some oversize.
    for (int i = 0; i < 60; i++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH + 1, DEPTH + 6)
                                         : $urandom_range(1, 8);
      send_pkt(len, 2'($urandom));
    end
    wait_drain("drain_random");
    check_stats("after_random");
    check_eq("words_out", words_out, exp_words);

    // Reset in the middle of a transfer.
    bg_en = 1'b0;
    gnt = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    send_pkt(3, 2'b01);
    t = 0;
    do begin @(negedge clk); t++; end while (!req && t < 100);
    check_eq("rst_test_req", req, 1);
    @(posedge clk); #1;
    gnt = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 100);
    check_eq("rst_test_xfer", out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_req", req, 0);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_last", out_last, 0);
    check_eq("mid_rst_addr", addr, 0);
    check_eq("mid_rst_out_data", out_data, 0);
    exp_q.delete();
    exp_tx = 0;
    exp_drop = 0;
    check_stats("mid_rst");
    gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("post_rst_req", req, 0);
      check_eq("post_rst_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send_pkt(2, 2'b11);
    @(negedge clk);
    check_eq("req_lat_e0", req, 0);
    @(negedge clk);
    check_eq("req_lat_e1", req, 1);
    check_eq("req_addr", addr, exp_q[0][DW-1:0]);
    @(posedge clk); #1;
    gnt = 1'b1;
    @(negedge clk);
    check_eq("gnt_lat_pre", out_valid, 0);
    @(negedge clk);
    check_eq("w0_valid", out_valid, 1);
    check_eq("w0_data", out_data, exp_q[0][DW-1:0]);
    check_eq("w0_last", out_last, 0);
    @(negedge clk);
    check_eq("w1_valid", out_valid, 1);
    check_eq("w1_data", out_data, exp_q[1][DW-1:0]);
    check_eq("w1_last", out_last, 1);
    @(negedge clk);
    check_eq("done_valid", out_valid, 0);
    check_eq("done_req", req, 0);
    check_stats("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
